// File: rtl/raymarch_pkg.sv
// Shared types for the ray-march video path: pixel colour, per-pixel raster
// tags carried through the output buffer, and default raster geometry.
package raymarch_pkg;

    localparam int DEFAULT_H_RES = 640;
    localparam int DEFAULT_V_RES = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // One buffered pixel: colour plus start-of-frame, end-of-line and
    // "belongs to the last line" markers captured when the pixel was accepted.
    typedef struct packed {
        rgb888_t rgb;
        logic    sof;
        logic    eol;
        logic    last_line;
    } pix_tag_t;

    localparam int PIX_TAG_W = $bits(pix_tag_t);

    // Map a colour to the 32-bit video beat layout {pad, r, g, b}.
    function automatic logic [31:0] rgb_to_tdata(input rgb888_t p);
        return {8'h00, p.r, p.g, p.b};
    endfunction

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Handshake bundles around the packer: the upstream pixel stream from the
// shading stage and the AXI4-Stream video output with its frame_done sideband.

interface pix_in_if;
    import raymarch_pkg::*;

    logic    frame_sync;
    logic    pix_valid;
    logic    pix_ready;
    rgb888_t pix_rgb;

    // Producer side (shading stage).
    modport master (
        output frame_sync,
        output pix_valid,
        output pix_rgb,
        input  pix_ready
    );

    // Consumer side (packer).
    modport slave (
        input  frame_sync,
        input  pix_valid,
        input  pix_rgb,
        output pix_ready
    );
endinterface

interface axis_video_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tuser;
    logic        tlast;
    logic        frame_done;

    // Beat source (packer).
    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        output frame_done,
        input  tready
    );

    // Beat sink (VDMA / frame writer).
    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        input  frame_done,
        output tready
    );
endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is held in
// its own register so the output never depends combinationally on the write
// side; storage is a plain array written on push and read on a clock edge.
module pixel_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic             push_en;
    logic             pop_en;

    assign full        = (count_reg == (AW+1)'(DEPTH));
    assign empty       = (count_reg == '0);
    // Pushes are refused when full even if a pop happens in the same cycle.
    assign push_en     = push & ~full;
    assign pop_en      = pop & ~empty;
    assign rd_ptr_next = rd_ptr_reg + AW'(1);
    assign dout        = dout_reg;

    // Storage write; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head register: loads the incoming word when it becomes the new head
    // (empty FIFO, or the only entry is leaving), otherwise the next stored word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg <= '0;
        end else if (push_en && (empty || (pop_en && count_reg == (AW+1)'(1)))) begin
            dout_reg <= din;
        end else if (pop_en) begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs shaded RGB888 pixels into 32-bit AXI4-Stream video beats. Pixels are
// tagged with frame/line markers from raster counters at the input, buffered
// so downstream backpressure only stalls the shader when the buffer is full.
module pixel_stream_packer
    import raymarch_pkg::*;
#(
    parameter int H_RES      = DEFAULT_H_RES,
    parameter int V_RES      = DEFAULT_V_RES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    pix_in_if.slave      pix,
    axis_video_if.master m_axis
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    logic [XW-1:0] x_reg, x_next;
    logic [YW-1:0] y_reg, y_next;
    logic          run_reg;
    logic          frame_done_reg;
    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    pix_tag_t      in_tag;
    pix_tag_t      head_tag;

    // run_reg keeps pix_ready low until the first edge after reset release.
    assign pix.pix_ready = run_reg & ~fifo_full;
    assign accept        = pix.pix_valid & pix.pix_ready;
    assign pop           = m_axis.tvalid & m_axis.tready;

    // Tag the incoming pixel with the current (pre-advance) raster position.
    always_comb begin
        in_tag.rgb       = pix.pix_rgb;
        in_tag.sof       = (x_reg == '0) && (y_reg == '0);
        in_tag.eol       = (x_reg == X_LAST);
        in_tag.last_line = (y_reg == Y_LAST);
    end

    // Raster advance; a frame_sync restart wins over an advance.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (pix.frame_sync) begin
            x_next = '0;
            y_next = '0;
        end else if (accept) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + YW'(1);
            end else begin
                x_next = x_reg + XW'(1);
            end
        end
    end

    // Raster counter and run-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg   <= '0;
            y_reg   <= '0;
            run_reg <= 1'b0;
        end else begin
            x_reg   <= x_next;
            y_reg   <= y_next;
            run_reg <= 1'b1;
        end
    end

    pixel_fifo #(
        .WIDTH (PIX_TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (in_tag),
        .pop   (pop),
        .dout  (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_axis.tvalid     = ~fifo_empty;
    assign m_axis.tdata      = rgb_to_tdata(head_tag.rgb);
    assign m_axis.tuser      = head_tag.sof;
    assign m_axis.tlast      = head_tag.eol;
    assign m_axis.frame_done = frame_done_reg;

    // Pulse once the final pixel of the frame has left toward the frame writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= pop & head_tag.eol & head_tag.last_line;
        end
    end

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench for pixel_stream_packer on a 4x2 raster with a 4-deep
// buffer: table-driven streaming, backpressure fill, random traffic over
// several frames, frame_sync restart and mid-frame reset, all backed by a
// scoreboard that predicts every beat from the input side.
module tb_pixel_stream_packer;
    import raymarch_pkg::*;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pix_in_if     pix ();
    axis_video_if axis ();

    pixel_stream_packer #(
        .H_RES      (H),
        .V_RES      (V),
        .FIFO_DEPTH (D)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix    (pix),
        .m_axis (axis)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
        logic        fd;
    } beat_t;

    beat_t       sb_q[$];
    int          mx = 0;
    int          my = 0;
    bit          exp_fd = 0;
    bit          stall_prev = 0;
    logic [31:0] hold_data;
    logic        hold_user, hold_last;
    int          cnt_user = 0, cnt_last = 0, cnt_fd = 0;

    // Reference model: predicts beats at the input, checks them at the output.
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            sb_q.delete();
            mx = 0;
            my = 0;
            exp_fd = 0;
            stall_prev = 0;
        end else begin
            check("frame_done", {31'd0, axis.frame_done}, {31'd0, exp_fd});
            if (axis.frame_done) cnt_fd++;
            check("tvalid_vs_model", {31'd0, axis.tvalid}, {31'd0, sb_q.size() != 0});
            if (pix.pix_ready) check("ready_while_full", {31'd0, sb_q.size() < D}, 32'd1);
            if (stall_prev) begin
                check("stall_tvalid", {31'd0, axis.tvalid}, 32'd1);
                check("stall_tdata", axis.tdata, hold_data);
                check("stall_tuser", {31'd0, axis.tuser}, {31'd0, hold_user});
                check("stall_tlast", {31'd0, axis.tlast}, {31'd0, hold_last});
            end
            stall_prev = axis.tvalid && !axis.tready;
            hold_data  = axis.tdata;
            hold_user  = axis.tuser;
            hold_last  = axis.tlast;
            exp_fd = 0;
            if (axis.tvalid && axis.tready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = sb_q.pop_front();
                    check("sb_tdata", axis.tdata, b.data);
                    check("sb_tuser", {31'd0, axis.tuser}, {31'd0, b.user});
                    check("sb_tlast", {31'd0, axis.tlast}, {31'd0, b.last});
                    exp_fd = b.fd;
                    if (axis.tuser) cnt_user++;
                    if (axis.tlast) cnt_last++;
                end
            end
            if (pix.pix_valid && pix.pix_ready) begin
                b.data = {8'h00, pix.pix_rgb};
                b.user = (mx == 0) && (my == 0);
                b.last = (mx == H - 1);
                b.fd   = (mx == H - 1) && (my == V - 1);
                sb_q.push_back(b);
            end
            if (pix.frame_sync) begin
                mx = 0;
                my = 0;
            end else if (pix.pix_valid && pix.pix_ready) begin
                if (mx == H - 1) begin
                    mx = 0;
                    my = (my == V - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    // Offer one pixel until accepted; returns 1 time unit after the accept edge.
    task automatic send(input logic [23:0] rgb, input bit sync);
        bit done = 0;
        int waited = 0;
        pix.pix_valid  = 1'b1;
        pix.pix_rgb    = rgb;
        pix.frame_sync = sync;
        while (!done) begin
            @(negedge clk);
            if (pix.pix_ready) done = 1;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    check("send_timeout", 32'd1, 32'd0);
                    done = 1;
                end
            end
        end
        pix.pix_valid  = 1'b0;
        pix.frame_sync = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        axis.tready = 1'b1;
        while ((sb_q.size() != 0 || axis.tvalid) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_timeout", {31'd0, c >= 100}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [23:0] rgb;
        logic [31:0] exp_data;
        logic        exp_user;
        logic        exp_last;
    } vec_t;

    vec_t tbl[8];
    bit   t3_done = 0;

    initial begin
        int acc;
        bit r;
        int guard;

        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit r;
        int guard;

        for (int i = 0; i < 8; i++) begin
            tbl[i].rgb      = 24'(i + 1);
            tbl[i].exp_data = 32'(i + 1);
            tbl[i].exp_user = (i == 0);
            tbl[i].exp_last = (i == 3) || (i == 7);
        end

        pix.pix_valid  = 1'b0;
        pix.frame_sync = 1'b0;
        pix.pix_rgb    = '0;
        axis.tready    = 1'b0;

        // Reset state (asynchronous assertion).
        #2 rst_n = 1'b0;
        #1;
        check("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        check("rst_pix_ready", {31'd0, pix.pix_ready}, 32'd0);
        check("rst_tdata", axis.tdata, 32'd0);
        check("rst_tuser", {31'd0, axis.tuser}, 32'd0);
        check("rst_tlast", {31'd0, axis.tlast}, 32'd0);
        check("rst_frame_done", {31'd0, axis.frame_done}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {31'd0, pix.pix_ready}, 32'd1);

        // 1: stream one frame with tready high.
        axis.tready = 1'b1;
        check("t1_idle_tvalid", {31'd0, axis.tvalid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].rgb, 1'b0);
            check("t1_tvalid", {31'd0, axis.tvalid}, 32'd1);
            check("t1_tdata", axis.tdata, tbl[i].exp_data);
            check("t1_tuser", {31'd0, axis.tuser}, {31'd0, tbl[i].exp_user});
            check("t1_tlast", {31'd0, axis.tlast}, {31'd0, tbl[i].exp_last});
        end
        @(posedge clk);
        #1;
        check("t1_frame_done", {31'd0, axis.frame_done}, 32'd1);
        check("t1_empty_after", {31'd0, axis.tvalid}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_frame_done_pulse", {31'd0, axis.frame_done}, 32'd0);

        // 2: backpressure fills the buffer, then release.
        axis.tready   = 1'b0;
        pix.pix_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            pix.pix_rgb = 24'(acc + 1);
            @(negedge clk);
            r = pix.pix_ready;
            @(posedge clk);
            #1;
            if (r) acc++;
        end
        check("t2_accepts", 32'(acc), 32'd4);
        check("t2_ready_low", {31'd0, pix.pix_ready}, 32'd0);
        check("t2_tdata_held", axis.tdata, 32'h00000001);
        axis.tready = 1'b1;
        guard = 0;
        while (acc < 8 && guard < 100) begin
            pix.pix_rgb = 24'(acc + 1);
            @(negedge clk);
            r = pix.pix_ready;
            @(posedge clk);
            #1;
            if (r) acc++;
            guard++;
        end
        pix.pix_valid = 1'b0;
        check("t2_total_accepts", 32'(acc), 32'd8);
        drain();
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // 3: random valid/ready over three frames.
        cnt_user = 0;
        cnt_last = 0;
        cnt_fd   = 0;
        fork
            begin
                while (!t3_done) begin
                    @(posedge clk);
                    #1;
                    axis.tready = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int i = 0; i < 3 * H * V; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(24'($urandom()), 1'b0);
                end
                t3_done = 1;
            end
        join
        drain();
        check("t3_tuser_count", 32'(cnt_user), 32'd3);
        check("t3_tlast_count", 32'(cnt_last), 32'd6);
        check("t3_frame_done_count", 32'(cnt_fd), 32'd3);

        // 4: frame_sync together with the accept of pixel x=2.
        axis.tready = 1'b1;
        send(24'h000040, 1'b0);
        send(24'h000041, 1'b0);
        send(24'h000042, 1'b1);
        check("t4_sync_tdata", axis.tdata, 32'h00000042);
        check("t4_sync_tuser", {31'd0, axis.tuser}, 32'd0);
        check("t4_sync_tlast", {31'd0, axis.tlast}, 32'd0);
        send(24'h000043, 1'b0);
        check("t4_next_tdata", axis.tdata, 32'h00000043);
        check("t4_next_tuser", {31'd0, axis.tuser}, 32'd1);
        drain();

        // 5: reset mid-frame with two beats pending.
        axis.tready = 1'b0;
        send(24'h000050, 1'b0);
        send(24'h000051, 1'b0);
        send(24'h000052, 1'b0);
        axis.tready = 1'b1;
        @(posedge clk);
        #1;
        axis.tready = 1'b0;
        check("t5_pending", 32'(sb_q.size()), 32'd2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t5_rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
        check("t5_rst_pix_ready", {31'd0, pix.pix_ready}, 32'd0);
        check("t5_rst_tdata", axis.tdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        axis.tready = 1'b1;
        send(24'h000077, 1'b0);
        check("t5_after_tdata", axis.tdata, 32'h00000077);
        check("t5_after_tuser", {31'd0, axis.tuser}, 32'd1);
        drain();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
